sap1_ctrl_seq: RTL and testbench

//  SAP-1 controller-sequencer: 6-state ring counter (T1..T6) that decodes the IR

---
 rtl/sap1_ctrl_seq_if.sv | 35 +++
 rtl/sap1_ctrl_seq.sv | 179 +++++++++++++++++
 tb/tb_sap1_ctrl_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_ctrl_seq_if.sv
// SAP-1 controller-sequencer bus: run/opcode inputs, ring state, control word,
// halt flag and MAR address-mux controls. The sequencer connects to the slave
// modport; the datapath/IR side connects to the master modport.
interface sap1_ctrl_seq_if;
    logic       RUN;
    logic [3:0] OP;
    logic [5:0] T;
    logic       CP;
    logic       EP;
    logic       LM;
    logic       CE;
    logic       LI;
    logic       EI;
    logic       LA;
    logic       EA;
    logic       SU;
    logic       EU;
    logic       LB;
    logic       LO;
    logic       HALT;
    logic       MUX_S;
    logic       MUX_E;

    modport master (
        output RUN, OP,
        input  T, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO,
        input  HALT, MUX_S, MUX_E
    );

    modport slave (
        input  RUN, OP,
        output T, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO,
        output HALT, MUX_S, MUX_E
    );
endinterface

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter plus opcode decode
// producing the datapath control word and the MAR address-mux controls.
// Optional build macro: SAP1_VAR_CYCLE_EN (variable machine cycle; the ring
// returns to T1 right after each opcode's last active state).
module sap1_ctrl_seq #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic           CLK,
    input  logic           CLR,
    sap1_ctrl_seq_if.slave bus
);

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } ring_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    ring_t state;
    ring_t last_t;
    ring_t ring_next;
    logic  halt_q;
    ctrl_t ctrl;

    // Last active T state of the current instruction (ring wraps after it)
    always_comb begin
        last_t = S_T6;
`ifdef SAP1_VAR_CYCLE_EN
        case (bus.OP)
            OP_LDA:         last_t = S_T5;
            OP_ADD, OP_SUB: last_t = S_T6;
            OP_OUT:         last_t = S_T4;
            OP_HLT:         last_t = S_T6;
            default:        last_t = S_T3;
        endcase
`endif
    end

    // Successor in the ring: rotate left, or wrap to T1 after the last state
    always_comb begin
        if (state == last_t) begin
            ring_next = S_T1;
        end else begin
            ring_next = ring_t'({state[4:0], state[5]});
        end
    end

    // Ring counter and halt latch; RUN gates only the T1 -> T2 step
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= S_T1;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            case (state)
                S_T1: begin
                    if (bus.RUN) begin
                        state <= ring_next;
                    end
                end
                S_T4: begin
                    if (bus.OP == OP_HLT) begin
                        halt_q <= 1'b1;
                    end else begin
                        state <= ring_next;
                    end
                end
                S_T2, S_T3, S_T5, S_T6: begin
                    state <= ring_next;
                end
                default: begin
                    state <= S_T1;
                end
            endcase
        end
    end

    // Control word decode from ring state and opcode; forced low in reset/halt
    always_comb begin
        ctrl = '0;
        if (!CLR && !halt_q) begin
            case (state)
                S_T1: begin
                    if (bus.RUN) begin
                        ctrl.ep = 1'b1;
                        ctrl.lm = 1'b1;
                    end
                end
                S_T2: begin
                    ctrl.cp = 1'b1;
                end
                S_T3: begin
                    ctrl.ce = 1'b1;
                    ctrl.li = 1'b1;
                end
                S_T4: begin
                    case (bus.OP)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ei = 1'b1;
                            ctrl.lm = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.ea = 1'b1;
                            ctrl.lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (bus.OP)
                        OP_LDA: begin
                            ctrl.ce = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ce = 1'b1;
                            ctrl.lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (bus.OP)
                        OP_ADD: begin
                            ctrl.eu = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl.eu = 1'b1;
                            ctrl.la = 1'b1;
                            ctrl.su = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.T     = state;
    assign bus.HALT  = halt_q;
    assign bus.CP    = ctrl.cp;
    assign bus.EP    = ctrl.ep;
    assign bus.LM    = ctrl.lm;
    assign bus.CE    = ctrl.ce;
    assign bus.LI    = ctrl.li;
    assign bus.EI    = ctrl.ei;
    assign bus.LA    = ctrl.la;
    assign bus.EA    = ctrl.ea;
    assign bus.SU    = ctrl.su;
    assign bus.EU    = ctrl.eu;
    assign bus.LB    = ctrl.lb;
    assign bus.LO    = ctrl.lo;
    assign bus.MUX_S = bus.RUN & ~halt_q & ~CLR;
    assign bus.MUX_E = ~CLR;

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// Bench for sap1_ctrl_seq: directed scenarios with literal expectations plus
// random RUN/OP/CLR traffic, all checked against a step-counter model.
module tb_sap1_ctrl_seq;

    logic CLK = 1'b0;
    logic CLR;

    sap1_ctrl_seq_if bus();

    sap1_ctrl_seq dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #50 CLK = ~CLK;

    // Control word bit positions: {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
    localparam logic [11:0] M_CP = 12'h800;
    localparam logic [11:0] M_EP = 12'h400;
    localparam logic [11:0] M_LM = 12'h200;
    localparam logic [11:0] M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080;
    localparam logic [11:0] M_EI = 12'h040;
    localparam logic [11:0] M_LA = 12'h020;
    localparam logic [11:0] M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008;
    localparam logic [11:0] M_EU = 12'h004;
    localparam logic [11:0] M_LB = 12'h002;
    localparam logic [11:0] M_LO = 12'h001;

`ifdef SAP1_VAR_CYCLE_EN
    localparam int LDA_LEN = 5;
`else
    localparam int LDA_LEN = 6;
`endif

    logic [11:0] ctrl;
    logic [4:0]  drivers;
    assign ctrl = {bus.CP, bus.EP, bus.LM, bus.CE, bus.LI, bus.EI,
                   bus.LA, bus.EA, bus.SU, bus.EU, bus.LB, bus.LO};
    assign drivers = {bus.EP, bus.CE, bus.EI, bus.EA, bus.EU};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          step   = 1;     // 1..6 = T1..T6
    bit          halted = 1'b0;
    bit          mvalid = 1'b0;
    logic [11:0] exec_tbl [16][3];   // per-opcode control words for T4..T6

    function automatic int last_step(input logic [3:0] op);
`ifdef SAP1_VAR_CYCLE_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            4'hE:       return 4;
            4'hF:       return 6;
            default:    return 3;
        endcase
`else
        return 6;
`endif
    endfunction

    function automatic logic [11:0] model_ctrl(input logic [3:0] op);
        if (CLR || halted) return '0;
        case (step)
            1:       return bus.RUN ? (M_EP | M_LM) : 12'h000;
            2:       return M_CP;
            3:       return M_CE | M_LI;
            default: return exec_tbl[op][step-4];
        endcase
    endfunction

    always @(posedge CLK) begin
        if (CLR) begin
            step   = 1;
            halted = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid && !halted) begin
            if (step == 1 && !bus.RUN) begin
                step = 1;
            end else if (step == 4 && bus.OP == 4'hF) begin
                halted = 1'b1;
            end else if (step == last_step(bus.OP)) begin
                step = 1;
            end else begin
                step = step + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (mvalid) begin
            chk("model_T", bus.T, 6'b000001 << (step - 1));
            chk("model_ctrl", ctrl, model_ctrl(bus.OP));
            chk("model_HALT", bus.HALT, halted);
            chk("model_MUX_S", bus.MUX_S, bus.RUN && !halted && !CLR);
            chk("model_MUX_E", bus.MUX_E, !CLR);
            chk("one_bus_driver", ($countones(drivers) > 1) ? 1 : 0, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic at_sample();
        @(negedge CLK);
        #1;
    endtask

    logic [11:0] lda_exp [6];
    logic [5:0]  t_exp;

    initial begin
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 3; j++)
                exec_tbl[i][j] = '0;
        exec_tbl[4'h0] = '{M_EI | M_LM, M_CE | M_LA, 12'h000};
        exec_tbl[4'h1] = '{M_EI | M_LM, M_CE | M_LB, M_EU | M_LA};
        exec_tbl[4'h2] = '{M_EI | M_LM, M_CE | M_LB, M_EU | M_LA | M_SU};
        exec_tbl[4'hE] = '{M_EA | M_LO, 12'h000, 12'h000};

        lda_exp = '{12'b0110_0000_0000, 12'b1000_0000_0000, 12'b0001_1000_0000,
                    12'b0010_0100_0000, 12'b0001_0010_0000, 12'b0000_0000_0000};

        // Reset: two edges with CLR high
        CLR     = 1'b1;
        bus.RUN = 1'b1;
        bus.OP  = 4'h0;
        cyc();
        cyc();
        at_sample();
        chk("rst_T", bus.T, 6'b000001);
        chk("rst_ctrl", ctrl, 12'h000);
        chk("rst_HALT", bus.HALT, 1'b0);
        chk("rst_MUX_E", bus.MUX_E, 1'b0);
        chk("rst_MUX_S", bus.MUX_S, 1'b0);

        // LDA sequence
        CLR = 1'b0;
        #1;
        chk("lda_T1_ctrl", ctrl, lda_exp[0]);
        chk("lda_T1_MUX_E", bus.MUX_E, 1'b1);
        for (int k = 1; k < LDA_LEN; k++) begin
            cyc();
            at_sample();
            t_exp = 6'b000001 << k;
            chk("lda_T", bus.T, t_exp);
            chk("lda_ctrl", ctrl, lda_exp[k]);
        end
        cyc();
        at_sample();
        chk("lda_wrap_T", bus.T, 6'b000001);

        // ADD: T6 exactly {EU,LA}
        bus.OP = 4'h1;
        repeat (5) cyc();
        at_sample();
        chk("add_T6_T", bus.T, 6'b100000);
        chk("add_T6_ctrl", ctrl, 12'b0000_0010_0100);
        cyc();

        // SUB: T6 exactly {SU,EU,LA}
        bus.OP = 4'h2;
        repeat (5) cyc();
        at_sample();
        chk("sub_T6_T", bus.T, 6'b100000);
        chk("sub_T6_ctrl", ctrl, 12'b0000_0010_1100);
        cyc();

        // HLT: halts at T4 and stays there until CLR
        bus.OP = 4'hF;
        repeat (3) cyc();
        at_sample();
        chk("hlt_T4_T", bus.T, 6'b001000);
        chk("hlt_T4_HALT", bus.HALT, 1'b0);
        cyc();
        repeat (20) begin
            at_sample();
            chk("hlt_hold_T", bus.T, 6'b001000);
            chk("hlt_hold_ctrl", ctrl, 12'h000);
            chk("hlt_hold_HALT", bus.HALT, 1'b1);
            chk("hlt_hold_MUX_S", bus.MUX_S, 1'b0);
            cyc();
        end
        CLR = 1'b1;
        cyc();
        CLR     = 1'b0;
        bus.RUN = 1'b0;
        at_sample();
        chk("hlt_clr_T", bus.T, 6'b000001);
        chk("hlt_clr_HALT", bus.HALT, 1'b0);

        // RUN=0 at T1 holds in program mode
        repeat (3) begin
            at_sample();
            chk("prog_T", bus.T, 6'b000001);
            chk("prog_ctrl", ctrl, 12'h000);
            chk("prog_MUX_S", bus.MUX_S, 1'b0);
            chk("prog_MUX_E", bus.MUX_E, 1'b1);
            cyc();
        end

        // RUN dropped at T3: instruction completes, then holds at T1
        bus.RUN = 1'b1;
        bus.OP  = 4'h1;
        cyc();
        cyc();
        bus.RUN = 1'b0;
        at_sample();
        chk("run_drop_T3", bus.T, 6'b000100);
        cyc();
        at_sample();
        chk("run_drop_T4", bus.T, 6'b001000);
        chk("run_drop_T4_ctrl", ctrl, 12'b0010_0100_0000);
        cyc();
        cyc();
        at_sample();
        chk("run_drop_T6", bus.T, 6'b100000);
        cyc();
        cyc();
        at_sample();
        chk("run_drop_hold_T1", bus.T, 6'b000001);

        // Every state x every opcode sweep (OP restored before each edge)
        bus.RUN = 1'b1;
        bus.OP  = 4'h1;
        repeat (12) begin
            at_sample();
            for (int op = 0; op < 16; op++) begin
                bus.OP = 4'(op);
                #1;
                chk("sweep_ctrl", ctrl, model_ctrl(4'(op)));
                chk("sweep_one_driver", ($countones(drivers) > 1) ? 1 : 0, 0);
            end
            bus.OP = 4'h1;
            cyc();
        end

        // Random traffic
        repeat (1500) begin
            cyc();
            bus.OP  = 4'($urandom_range(0, 15));
            bus.RUN = ($urandom_range(0, 7) != 0);
            CLR     = ($urandom_range(0, 39) == 0);
        end
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
